// File: rtl/multicycle_controller_if.sv
// Decoded-instruction flag bundle and the req/ack memory bus between the
// multi-cycle controller (master) and the memory port (slave).
package multicycle_controller_pkg;
  typedef struct packed {
    logic branch;
    logic j_type;
    logic r_type;
    logic link;
    logic load;
    logic store;
    logic writeback;
    logic no_overflow;
  } flags_t;
endpackage

interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// overflow and memory-timeout exceptions redirecting the PC to the vector.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  flags_t                      flags,
  input  logic                        branch_taken,
  input  logic                        alu_overflow,
  multicycle_controller_if.master     mem,
  output logic                        ir_load,
  output logic                        pc_load,
  output logic [2:0]                  pc_src,
  output logic                        reg_write,
  output logic [1:0]                  wb_sel,
  output logic                        exception,
  output logic                        instr_retired,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_EXCEPT    = 3'd5
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [9:0] tmo_cnt;
  logic       in_mem;
  logic       tmo_hit;
  logic       mem_req_c;
  logic       mem_we_c;
  logic       mem_addr_sel_c;

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign tmo_hit = in_mem && !mem.mem_ack && (tmo_cnt == TMO_LAST);

  // The counter only runs while a request is outstanding; leaving FETCH/MEMORY
  // (ack or timeout) returns it to zero so each new request starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (!in_mem || mem.mem_ack || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 10'd1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ack)  state_d = S_DECODE;
        else if (tmo_hit) state_d = S_EXCEPT;
        else              state_d = S_FETCH;
      end
      S_DECODE: state_d = (flags == '0) ? S_FETCH : S_EXECUTE;
      S_EXECUTE: begin
        if (flags.j_type)                                         state_d = S_FETCH;
        else if (flags.load || flags.store)                       state_d = S_MEMORY;
        else if (flags.writeback && alu_overflow && !flags.no_overflow) state_d = S_EXCEPT;
        else if (flags.writeback)                                 state_d = S_WRITEBACK;
        else                                                      state_d = S_FETCH;
      end
      S_MEMORY: begin
        if (mem.mem_ack)  state_d = flags.store ? S_FETCH : S_WRITEBACK;
        else if (tmo_hit) state_d = S_EXCEPT;
        else              state_d = S_MEMORY;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_EXCEPT:    state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Reset masks every output so no strobe escapes during the reset cycle.
  always_comb begin
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_load        = 1'b0;
    pc_load        = 1'b0;
    pc_src         = 3'd0;
    reg_write      = 1'b0;
    wb_sel         = 2'd0;
    exception      = 1'b0;
    instr_retired  = 1'b0;
    state          = 3'd0;
    if (!reset) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req_c = 1'b1;
          if (mem.mem_ack) begin
            ir_load = 1'b1;
            pc_load = 1'b1;
          end
        end
        S_DECODE: instr_retired = (flags == '0);
        S_EXECUTE: begin
          if (flags.j_type) begin
            pc_load       = 1'b1;
            pc_src        = flags.r_type ? 3'd3 : 3'd2;
            reg_write     = flags.link;
            wb_sel        = flags.link ? 2'd2 : 2'd0;
            instr_retired = 1'b1;
          end else if (!flags.load && !flags.store && !flags.writeback) begin
            pc_load       = branch_taken;
            pc_src        = branch_taken ? 3'd1 : 3'd0;
            instr_retired = 1'b1;
          end
        end
        S_MEMORY: begin
          mem_req_c      = 1'b1;
          mem_addr_sel_c = 1'b1;
          mem_we_c       = flags.store;
          instr_retired  = mem.mem_ack && flags.store;
        end
        S_WRITEBACK: begin
          reg_write     = 1'b1;
          wb_sel        = flags.load ? 2'd1 : 2'd0;
          instr_retired = 1'b1;
        end
        S_EXCEPT: begin
          pc_load   = 1'b1;
          pc_src    = 3'd4;
          exception = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req      = mem_req_c;
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// for each instruction class, the handshake, exceptions and reset.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam bit [7:0] FB  = 8'h80, FJ = 8'h40, FR = 8'h20, FL = 8'h10;
  localparam bit [7:0] FLD = 8'h08, FST = 8'h04, FWB = 8'h02, FNO = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  flags_t     flags;
  logic       branch_taken;
  logic       alu_overflow;
  logic       ir_load, pc_load, reg_write, exception, instr_retired;
  logic [2:0] pc_src, state;
  logic [1:0] wb_sel;
  logic [15:0] obs;
  int n_tests = 0;
  int n_fail  = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .flags         (flags),
    .branch_taken  (branch_taken),
    .alu_overflow  (alu_overflow),
    .mem           (bus),
    .ir_load       (ir_load),
    .pc_load       (pc_load),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .exception     (exception),
    .instr_retired (instr_retired),
    .state         (state)
  );

  always #5 clk = ~clk;

  assign obs = {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_load, pc_load,
                pc_src, reg_write, wb_sel, exception, instr_retired};

  // Packs expected outputs in the same order as obs.
  function automatic logic [15:0] ov(logic [2:0] st, bit req, bit we, bit asel, bit irl,
                                     bit pcl, logic [2:0] pcs, bit rw, logic [1:0] wbs,
                                     bit exc, bit ret);
    return {st, req, we, asel, irl, pcl, pcs, rw, wbs, exc, ret};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Common expected vectors
  function automatic logic [15:0] v_fetch();   return ov(0,1,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] v_fetchak(); return ov(0,1,0,0,1,1,0,0,0,0,0); endfunction
  function automatic logic [15:0] v_dec();     return ov(1,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] v_exe();     return ov(2,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] v_exc();     return ov(5,0,0,0,0,1,4,0,0,1,0); endfunction

  task automatic test_reset();
    reset = 1'b1; flags = flags_t'(FLD | FWB); branch_taken = 1'b1; alu_overflow = 1'b1;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (obs !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h expected %h", i, obs, 16'h0);
      end
    end
    reset = 1'b0; branch_taken = 1'b0; alu_overflow = 1'b0; bus.mem_ack = 1'b0;
    #1;
    n_tests++;
    if (obs !== v_fetch()) begin
      n_fail++;
      $display("FAIL reset_to_fetch: got %h expected %h", obs, v_fetch());
    end
  endtask

  task automatic test_addi();
    logic [15:0] e[5];
    bit [4:0] a = 5'b00001, o = 5'b01000;
    e = '{v_fetchak(), v_dec(), v_exe(), ov(4,0,0,0,0,0,0,1,0,0,1), v_fetch()};
    flags = flags_t'(FWB);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = o[i]; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL addi cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [15:0] e[8];
    bit [7:0] a = 8'b0010_0111;
    e = '{v_fetchak(), v_dec(), v_exe(), ov(3,1,0,1,0,0,0,0,0,0,0), ov(3,1,0,1,0,0,0,0,0,0,0),
          ov(3,1,0,1,0,0,0,0,0,0,0), ov(4,0,0,0,0,0,0,1,1,0,1), v_fetch()};
    flags = flags_t'(FLD | FWB);
    for (int i = 0; i < 8; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_store();
    logic [15:0] e[5];
    bit [4:0] a = 5'b01001;
    e = '{v_fetchak(), v_dec(), v_exe(), ov(3,1,1,1,0,0,0,0,0,0,1), v_fetch()};
    flags = flags_t'(FST);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL store cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_jump(input bit [7:0] f, input logic [15:0] exe_exp, input string nm);
    logic [15:0] e[4];
    bit [3:0] a = 4'b0001;
    e = '{v_fetchak(), v_dec(), exe_exp, v_fetch()};
    flags = flags_t'(f);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL %s cycle %0d: got %h expected %h", nm, i, obs, e[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_branch(input bit taken, input string nm);
    logic [15:0] e[4];
    bit [3:0] a = 4'b0001;
    bit [3:0] b;
    b = taken ? 4'b0100 : 4'b0010;
    e = '{v_fetchak(), v_dec(),
          taken ? ov(2,0,0,0,0,1,1,0,0,0,1) : ov(2,0,0,0,0,0,0,0,0,0,1), v_fetch()};
    flags = flags_t'(FB);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = a[i]; branch_taken = b[i]; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL %s cycle %0d: got %h expected %h", nm, i, obs, e[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_overflow(input bit [7:0] f, input bit trap, input string nm);
    logic [15:0] e[5];
    bit [4:0] a = 5'b00001, o = 5'b00100;
    e = '{v_fetchak(), v_dec(), v_exe(),
          trap ? v_exc() : ov(4,0,0,0,0,0,0,1,0,0,1), v_fetch()};
    flags = flags_t'(f);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = o[i]; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL %s cycle %0d: got %h expected %h", nm, i, obs, e[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_fetch_timeout();
    logic [15:0] e[6];
    e = '{v_fetch(), v_fetch(), v_fetch(), v_fetch(), v_exc(), v_fetch()};
    flags = flags_t'(FWB);
    for (int i = 0; i < 6; i++) begin
      bus.mem_ack = 1'b0; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL fetch_timeout cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_ack_wins_nop();
    logic [15:0] e[6];
    bit [5:0] a = 6'b001000;
    e = '{v_fetch(), v_fetch(), v_fetch(), v_fetchak(), ov(1,0,0,0,0,0,0,0,0,0,1), v_fetch()};
    flags = flags_t'(8'h00);
    for (int i = 0; i < 6; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL ack_wins_nop cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_store_timeout();
    logic [15:0] e[9];
    bit [8:0] a = 9'b000000001;
    e = '{v_fetchak(), v_dec(), v_exe(), ov(3,1,1,1,0,0,0,0,0,0,0), ov(3,1,1,1,0,0,0,0,0,0,0),
          ov(3,1,1,1,0,0,0,0,0,0,0), ov(3,1,1,1,0,0,0,0,0,0,0), v_exc(), v_fetch()};
    flags = flags_t'(FST);
    for (int i = 0; i < 9; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL store_timeout cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 8) tick();
    end
  endtask

  task automatic test_reset_mid_memory();
    logic [15:0] e[4];
    bit [3:0] a = 4'b0001;
    e = '{v_fetchak(), v_dec(), v_exe(), ov(3,1,0,1,0,0,0,0,0,0,0)};
    flags = flags_t'(FLD | FWB);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = a[i]; branch_taken = 1'b0; alu_overflow = 1'b0; #1;
      n_tests++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL reset_mid cycle %0d: got %h expected %h", i, obs, e[i]);
      end
      tick();
    end
    reset = 1'b1; bus.mem_ack = 1'b1; #1;
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected %h", obs, 16'h0);
    end
    tick();
    reset = 1'b0; bus.mem_ack = 1'b0; #1;
    n_tests++;
    if (obs !== v_fetch()) begin
      n_fail++; $display("FAIL reset_mid_fetch: got %h expected %h", obs, v_fetch());
    end
  endtask

  initial begin
    reset = 1'b1; flags = flags_t'(8'h00); branch_taken = 1'b0; alu_overflow = 1'b0;
    bus.mem_ack = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_store();
    test_jump(FJ | FL, ov(2,0,0,0,0,1,2,1,2,0,1), "jal");
    test_jump(FJ | FR | FL, ov(2,0,0,0,0,1,3,1,2,0,1), "jalr");
    test_jump(FJ, ov(2,0,0,0,0,1,2,0,0,0,1), "j");
    test_branch(1'b0, "beq_not_taken");
    test_branch(1'b1, "beq_taken");
    test_overflow(FR | FWB, 1'b1, "add_overflow");
    test_overflow(FWB | FNO, 1'b0, "addiu_no_trap");
    test_fetch_timeout();
    test_ack_wins_nop();
    test_store_timeout();
    test_reset_mid_memory();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing FSM for the processor core: it takes the decoded `flags_t` bundle from the instruction decoder, which is driven by the instruction register, and steps each instruction through fetch, decode, execute, memory and writeback. It drives the IR/PC load strobes, the PC-source and writeback-source muxes, the register-file write enable and a req/ack memory handshake. It also detects ALU overflow and memory time-outs and redirects the PC to the exception vector.

## Interface
- `MEM_TIMEOUT`, 255: max cycles `mem_req` may stay high without `mem_ack` before a bus-error exception; range 1..1023.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `flags` in `flags_t`: decoder output for the current IR; valid from DECODE onward.
- `branch_taken` in 1: branch comparator result; sampled in EXECUTE only.
- `alu_overflow` in 1: signed overflow of the current ALU result; sampled in EXECUTE only.
- `mem_ack` in 1: memory completion; meaningful only while `mem_req`=1.
- `mem_req` out 1: memory request; held until ack.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `ir_load` out 1: IR captures memory read data.
- `pc_load` out 1: PC captures the `pc_src` selection.
- `pc_src` out 3: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (jr/jalr), 4 = exception vector.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = link (PC+4).
- `exception` out 1: one-cycle pulse on exception entry.
- `instr_retired` out 1: one-cycle pulse when an instruction completes.
- `state` out 3: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, EXCEPT=5. Codes 6 and 7 → FETCH next cycle.
- Outputs are combinational from state and inputs. Every output not listed for a state is 0.
- While `reset`=1, all outputs are forced to 0. At the edge, state ← FETCH and the timeout counter ← 0.
- FETCH: `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - On `mem_ack`: `ir_load`=1, `pc_load`=1, `pc_src`=0; next state DECODE.
- DECODE: register read, one cycle.
  - If `flags`==0 (nop or unrecognised): `instr_retired`=1; next state FETCH.
  - Otherwise next state EXECUTE.
- EXECUTE, evaluated in this priority order:
  1. `j_type`: `pc_load`=1, `pc_src` = `r_type` ? 3 : 2. If `link`, also `reg_write`=1 with `wb_sel`=2 in the same cycle, so the old PC+4 is written. `instr_retired`=1; next state FETCH.
  2. `load` or `store`: next state MEMORY.
  3. `writeback` && `alu_overflow` && !`no_overflow`: next state EXCEPT; no register write.
  4. `writeback`: next state WRITEBACK.
  5. Otherwise (branch): if `branch_taken`, `pc_load`=1 and `pc_src`=1. `instr_retired`=1; next state FETCH.
- MEMORY: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=`store`.
  - On `mem_ack` for a store: `instr_retired`=1; next state FETCH.
  - On `mem_ack` for a load: next state WRITEBACK. The datapath latches read data on ack.
- WRITEBACK: `reg_write`=1, `wb_sel` = `load` ? 1 : 0, `instr_retired`=1; next state FETCH.
- EXCEPT: `pc_load`=1, `pc_src`=4, `exception`=1; next state FETCH.
- Timeout counter (10 bits):
  - Cleared on entry to FETCH or MEMORY and on `mem_ack`.
  - Increments each cycle in FETCH or MEMORY without ack.
  - When the counter equals `MEM_TIMEOUT-1` and there is no ack, next state is EXCEPT and the request is abandoned.
  - An ack in that same cycle wins over the timeout.

## Timing
- Handshake:
  - `mem_ack` is sampled in the cycle `mem_req`=1.
  - `mem_req` drops in the cycle after ack because the state changes; it may fall without ack only on timeout or reset.
  - `mem_ack` while `mem_req`=0 is ignored.
- Latency with zero-wait memory (ack in the first request cycle):
  - nop: 2 cycles.
  - Branch or jump: 3 cycles.
  - ALU op or store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds 1 cycle.
- Overflow exception: 4 cycles (FETCH, DECODE, EXECUTE, EXCEPT). `exception` is high in cycle 4.
- Timeout: with no ack, EXCEPT follows exactly `MEM_TIMEOUT` request cycles.
- Reset mid-operation: state returns to FETCH at the next edge and `mem_req` is low during reset. No `reg_write`, `pc_load` or `exception` is issued in the reset cycle.
- Exactly one `instr_retired` or `exception` pulse per instruction; never both in the same cycle.

## Test plan
- Reset, then addi with ack in the first cycle → `state` sequence 0,1,2,4,0. `reg_write`=1 and `wb_sel`=0 only in cycle 4. `instr_retired` pulses once.
- lw with 2 wait cycles in MEMORY → `mem_req`=1 and `mem_addr_sel`=1 for 3 cycles, then WRITEBACK with `wb_sel`=1. Total 7 cycles.
- jal → in EXECUTE: `pc_load`=1, `pc_src`=2, `reg_write`=1, `wb_sel`=2. Next state FETCH.
- beq with `branch_taken`=0, then a second beq with `branch_taken`=1 → first: no `pc_load` in EXECUTE; second: `pc_load`=1, `pc_src`=1.
- add with `alu_overflow`=1 → EXCEPT with `pc_src`=4 and `exception`=1, no `reg_write`. The same stimulus with addiu (`no_overflow`) → normal WRITEBACK.
- `MEM_TIMEOUT`=4, fetch with no ack → 4 request cycles then EXCEPT. Separately, reset asserted mid-MEMORY → all outputs 0 and next state FETCH.
